// File: rtl/prei_md_buf_ctrl.sv
// prei_md_buf_ctrl: controller for the 85-entry pre-intra mode-decision buffer.
// Write phase maps (size, z-index) onto one RAM entry per quadtree node of a
// 64x64 LCU. The read phase streams all 85 entries in address order under
// valid/ready flow control. RAM pins are low-active and driven combinationally.
// Optional build macro: PREI_MD_CLR_EN adds a clear sweep (CLR state) that
// fills every entry with CLR_MODE before the write phase opens.
module prei_md_buf_ctrl #(
  parameter int ADR_WD   = 7,
  parameter int ADR      = 85,
  parameter int DAT_WD   = 6,
  parameter int CLR_MODE = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              lcu_start_i,
  input  logic              md_val_i,
  output logic              md_rdy_o,
  input  logic [1:0]        md_size_i,
  input  logic [5:0]        md_idx_i,
  input  logic [DAT_WD-1:0] md_mode_i,
  input  logic              rd_start_i,
  output logic              out_val_o,
  input  logic              out_rdy_i,
  output logic [ADR_WD-1:0] out_adr_o,
  output logic [DAT_WD-1:0] out_mode_o,
  output logic              out_last_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADR_WD-1:0] ram_adr_o,
  output logic              ram_wr_ena_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_rd_ena_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
`ifdef PREI_MD_CLR_EN
  localparam logic [1:0] S_CLR  = 2'd1;
`endif
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RD   = 2'd3;

  localparam logic [ADR_WD-1:0] LAST_ADR = ADR_WD'(ADR - 1);

  logic [1:0]        state_q, state_d;
  logic [ADR_WD-1:0] rp_q, rp_d;          // read pointer, doubles as clear pointer
  logic [ADR_WD-1:0] out_adr_q, out_adr_d;
  logic              out_val_q, out_val_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              idx_ok;
  logic [ADR_WD-1:0] md_base;
  logic [ADR_WD-1:0] md_adr;
  logic              wr_fire;
  logic              rd_fire;
  logic              clr_fire;
  logic              last_hs;

  // Quadtree address map: level base plus z-index, with per-level range check
  always_comb begin
    idx_ok  = 1'b1;
    md_base = ADR_WD'(21);
    case (md_size_i)
      2'd3: begin idx_ok = (md_idx_i == 6'd0);      md_base = ADR_WD'(0); end
      2'd2: begin idx_ok = (md_idx_i[5:2] == 4'd0); md_base = ADR_WD'(1); end
      2'd1: begin idx_ok = (md_idx_i[5:4] == 2'd0); md_base = ADR_WD'(5); end
      default: begin idx_ok = 1'b1;                 md_base = ADR_WD'(21); end
    endcase
    md_adr = md_base + ADR_WD'(md_idx_i);
  end

`ifdef PREI_MD_CLR_EN
  assign clr_fire = (state_q == S_CLR);
`else
  assign clr_fire = 1'b0;
`endif

  assign wr_fire = (state_q == S_WR) && md_val_i && idx_ok;
  // A new read may only be issued when the output register is free or draining;
  // under stall no read is issued so the RAM keeps its Q and out_mode_o holds.
  assign rd_fire = (state_q == S_RD) && (rp_q <= LAST_ADR) && (!out_val_q || out_rdy_i);
  assign last_hs = out_val_q && out_rdy_i && (out_adr_q == LAST_ADR);

  // RAM pin drive: states are exclusive, so the two enables never overlap
  always_comb begin
    ram_wr_ena_o = 1'b1;
    ram_rd_ena_o = 1'b1;
    ram_adr_o    = '0;
    ram_wr_dat_o = '0;
    if (wr_fire) begin
      ram_wr_ena_o = 1'b0;
      ram_adr_o    = md_adr;
      ram_wr_dat_o = md_mode_i;
    end else if (clr_fire) begin
      ram_wr_ena_o = 1'b0;
      ram_adr_o    = rp_q;
      ram_wr_dat_o = DAT_WD'(CLR_MODE);
    end else if (rd_fire) begin
      ram_rd_ena_o = 1'b0;
      ram_adr_o    = rp_q;
    end
  end

  // Phase sequencing, pointer advance and output register next-state
  always_comb begin
    state_d   = state_q;
    rp_d      = rp_q;
    out_adr_d = out_adr_q;
    err_d     = err_q;
    done_d    = 1'b0;
    out_val_d = rd_fire || (out_val_q && !out_rdy_i);
    case (state_q)
      S_IDLE: begin
        if (lcu_start_i) begin
          err_d = 1'b0;
          rp_d  = '0;
`ifdef PREI_MD_CLR_EN
          state_d = S_CLR;
`else
          state_d = S_WR;
`endif
        end
      end
`ifdef PREI_MD_CLR_EN
      S_CLR: begin
        rp_d = rp_q + ADR_WD'(1);
        if (rp_q == LAST_ADR) begin
          rp_d    = '0;
          state_d = S_WR;
        end
      end
`endif
      S_WR: begin
        if (md_val_i && !idx_ok) err_d = 1'b1;
        if (rd_start_i) begin
          rp_d    = '0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (rd_fire) begin
          rp_d      = rp_q + ADR_WD'(1);
          out_adr_d = rp_q;
        end
        if (last_hs) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      rp_q      <= '0;
      out_adr_q <= '0;
      out_val_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rp_q      <= rp_d;
      out_adr_q <= out_adr_d;
      out_val_q <= out_val_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign md_rdy_o   = (state_q == S_WR);
  assign out_val_o  = out_val_q;
  assign out_adr_o  = out_adr_q;
  assign out_mode_o = ram_rd_dat_i;
  assign out_last_o = out_val_q && (out_adr_q == LAST_ADR);
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: doc/prei_md_buf_ctrl.md
Name: prei_md_buf_ctrl

Overview:
- Controller for the 85x6 pre-intra mode-decision buffer. The buffer is a single-port RAM with low-active enables, one entry per quadtree node of a 64x64 LCU.
- Write phase: accepts per-partition mode decisions from the pre-intra search, maps (size, z-index) to a RAM address and writes it.
- Read phase: streams all 85 modes, in address order, to the downstream consumer with valid/ready flow control.
- Sits between the pre-intra search core and the mode RAM; drives the RAM's address, enable and data pins directly.

Parameters:
- ADR_WD, 7, RAM address width.
- ADR, 85, number of RAM entries.
- DAT_WD, 6, mode width.
- CLR_MODE, 1, value written during the clear sweep (DC mode).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- lcu_start_i  in  1  pulse; begins a new LCU write phase
- md_val_i  in  1  mode-decision valid
- md_rdy_o  out  1  mode-decision ready
- md_size_i  in  2  0=8x8, 1=16x16, 2=32x32, 3=64x64
- md_idx_i  in  6  z-order index within its level
- md_mode_i  in  DAT_WD  mode value
- rd_start_i  in  1  pulse; ends the write phase and starts the read stream
- out_val_o  out  1  stream valid
- out_rdy_i  in  1  stream ready
- out_adr_o  out  ADR_WD  address (node id) of the current out_mode_o
- out_mode_o  out  DAT_WD  mode value
- out_last_o  out  1  high with entry 84
- done_o  out  1  one-cycle pulse after the last handshake
- err_o  out  1  sticky; out-of-range index seen
- ram_adr_o  out  ADR_WD  RAM address
- ram_wr_ena_o  out  1  RAM write enable, low active
- ram_wr_dat_o  out  DAT_WD  RAM write data
- ram_rd_ena_o  out  1  RAM read enable, low active
- ram_rd_dat_i  in  DAT_WD  RAM read data; 1-cycle latency; held while no read is issued

Behaviour:
- Reset values: md_rdy_o=0, out_val_o=0, out_adr_o=0, out_last_o=0, done_o=0, err_o=0, ram_wr_ena_o=1, ram_rd_ena_o=1, ram_adr_o=0, ram_wr_dat_o=0. FSM resets to IDLE. Reset mid-operation aborts the phase; RAM contents are left untouched.
- FSM states: IDLE, (CLR), WR, RD.
  - IDLE -> WR on lcu_start_i (-> CLR when the optional feature is enabled).
  - WR -> RD on rd_start_i.
  - RD -> IDLE after the out_last_o handshake. done_o pulses the cycle after that handshake.
  - lcu_start_i outside IDLE is ignored. rd_start_i outside WR is ignored.
- Address map: adr = base(size) + idx, with base 3->0, 2->1, 1->5, 0->21. Legal idx ranges per size: 0, 0..3, 0..15, 0..63.
- WR state:
  - md_rdy_o=1.
  - On md_val_i && in-range idx: ram_wr_ena_o=0 and ram_adr_o=adr in the same cycle, combinationally.
  - Out-of-range idx: handshake completes, no write, err_o set. err_o clears on lcu_start_i.
  - md_val_i with rd_start_i in the same cycle: the write is performed, then the FSM moves to RD.
  - Rewriting the same address: last write wins.
- RD state:
  - Internal read pointer rp runs 0..84. A read is issued (ram_rd_ena_o=0, ram_adr_o=rp) when rp<=84 and (!out_val_o || out_rdy_i).
  - out_val_o registers "read issued"; out_adr_o registers rp.
  - out_mode_o = ram_rd_dat_i, combinational.
  - Under stall no read is issued, so the RAM holds Q and out_mode_o stays stable.
  - Throughput is 1 entry/cycle with out_rdy_i high. First out_val_o appears 2 cycles after rd_start_i.
  - out_last_o = out_val_o && out_adr_o==84.
- Read and write enables are never both low in the same cycle.

Optional Feature:
- Macro PREI_MD_CLR_EN.
- Defined: lcu_start_i enters CLR. CLR writes CLR_MODE to addresses 0..84, one per cycle (85 cycles), with md_rdy_o=0, then enters WR. Unwritten nodes therefore read back as CLR_MODE.
- Undefined: the CLR state does not exist; IDLE->WR is direct and unwritten entries return stale RAM data.

Test Plan:
- lcu_start; write size3 idx0 mode 26, size2 idx3 mode 10, size0 idx63 mode 34; rd_start, out_rdy=1 -> stream entry 0=26, 4=10, 84=34; out_last with out_adr=84; done_o pulses 1 cycle later; 85 beats in 85 consecutive cycles.
- Read with out_rdy toggling 1,0,0,1 -> out_mode/out_adr held during stall; no RAM read issued while stalled; no entry lost or repeated.
- size2 idx5 mode 7 -> no RAM write, err_o=1; next lcu_start clears err_o.
- md_val (size1 idx0 mode 18) in the same cycle as rd_start -> entry 5 reads back 18; FSM in RD next cycle.
- rstn low during RD at entry 40 -> all outputs at reset values; a fresh lcu_start/rd_start streams from address 0.
- PREI_MD_CLR_EN defined: lcu_start then md_rdy low 85 cycles; write only size0 idx0=3 -> readback entry 21=3, all others =1.
